// File: rtl/mem_pkg.sv
// Shared constants for the behavioural memories beside the RV64 core.
package mem_pkg;
    localparam int DATA_W    = 64;
    localparam int BYTE_W    = 8;
    localparam int NUM_LANES = DATA_W / BYTE_W;

    // Data memory: addr is byte address [31:3]
    localparam int DMEM_DEPTH     = 512;
    localparam int DMEM_ADDR_WIDE = 29;

    // Instruction memory: addr is byte address [31:2]
    localparam int IMEM_DEPTH     = 512;
    localparam int IMEM_ADDR_WIDE = 30;

    typedef logic [BYTE_W-1:0] lane_t;
endpackage

// File: rtl/byte_lane_merge.sv
// Combinational byte-lane merge: lanes with wmask set take wdata, others keep old.
module byte_lane_merge
    import mem_pkg::*;
(
    input  logic [DATA_W-1:0]    old_data,
    input  logic [DATA_W-1:0]    wdata,
    input  logic [NUM_LANES-1:0] wmask,
    output logic [DATA_W-1:0]    merged
);
    genvar i;
    generate
        for (i = 0; i < NUM_LANES; i++) begin : g_lane
            // Per-lane select between the stored byte and the incoming byte
            assign merged[i*BYTE_W +: BYTE_W] = wmask[i] ? wdata[i*BYTE_W +: BYTE_W]
                                                         : old_data[i*BYTE_W +: BYTE_W];
        end
    endgenerate
endmodule

// File: rtl/data_mem_model.sv
// Data memory for the load/store port: 64-bit words, per-byte masked
// synchronous writes, combinational reads, out-of-range accesses inert.
module data_mem_model
    import mem_pkg::*;
#(
    parameter int DEPTH     = DMEM_DEPTH,
    parameter int ADDR_WIDE = DMEM_ADDR_WIDE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDR_WIDE-1:0] addr,
    output logic [DATA_W-1:0]    rdata,
    input  logic                 wr_en,
    input  logic [DATA_W-1:0]    wdata,
    input  logic [NUM_LANES-1:0] wmask
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [IDX_W-1:0]  idx;
    logic              in_range;
    logic [DATA_W-1:0] cur_word;
    logic [DATA_W-1:0] merged;

    // Range check in full address width so high addresses never alias
    assign in_range = (addr < ADDR_WIDE'(DEPTH));
    assign idx      = addr[IDX_W-1:0];
    assign cur_word = in_range ? mem[idx] : '0;

    // Read path: zero while in reset or out of range
    assign rdata = (rst || !in_range) ? '0 : cur_word;

    byte_lane_merge u_merge (
        .old_data (cur_word),
        .wdata    (wdata),
        .wmask    (wmask),
        .merged   (merged)
    );

    // Storage: async clear on reset, masked write of the addressed word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en && in_range) begin
            mem[idx] <= merged;
        end
    end
endmodule

// File: tb/tb_data_mem_model.sv
// Directed self-checking bench for data_mem_model.
module tb_data_mem_model;
    logic        clk;
    logic        rst;
    logic [28:0] addr;
    logic [63:0] rdata;
    logic        wr_en;
    logic [63:0] wdata;
    logic [7:0]  wmask;

    int checks = 0;
    int errors = 0;

    data_mem_model dut (
        .clk   (clk),
        .rst   (rst),
        .addr  (addr),
        .rdata (rdata),
        .wr_en (wr_en),
        .wdata (wdata),
        .wmask (wmask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one write cycle, settle just after the capturing edge
    task automatic do_write(input logic [28:0] a, input logic [63:0] d,
                            input logic [7:0] m, input logic en);
        @(negedge clk);
        addr  = a;
        wdata = d;
        wmask = m;
        wr_en = en;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic set_addr(input logic [28:0] a);
        addr = a;
        #1;
    endtask

    task automatic test_reset();
        set_addr(29'd3);
        checks++;
        if (rdata !== 64'h0) begin
            errors++;
            $display("FAIL reset_state: got %h want %h", rdata, 64'h0);
        end
        rst = 1'b0;
        do_write(29'd3, 64'hDEADBEEF_CAFEF00D, 8'hFF, 1'b1);
        checks++;
        if (rdata !== 64'hDEADBEEF_CAFEF00D) begin
            errors++;
            $display("FAIL preload: got %h want %h", rdata, 64'hDEADBEEF_CAFEF00D);
        end
        // async pulse between edges
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (rdata !== 64'h0) begin
            errors++;
            $display("FAIL reset_async: got %h want %h", rdata, 64'h0);
        end
        // write attempted while in reset must be ignored
        addr = 29'd4; wdata = 64'h77; wmask = 8'hFF; wr_en = 1'b1;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rst = 1'b0;
        set_addr(29'd3);
        checks++;
        if (rdata !== 64'h0) begin
            errors++;
            $display("FAIL reset_cleared: got %h want %h", rdata, 64'h0);
        end
        set_addr(29'd4);
        checks++;
        if (rdata !== 64'h0) begin
            errors++;
            $display("FAIL reset_write_ignored: got %h want %h", rdata, 64'h0);
        end
    endtask

    task automatic test_full_write();
        do_write(29'd5, 64'h0123_4567_89AB_CDEF, 8'hFF, 1'b1);
        checks++;
        if (rdata !== 64'h0123_4567_89AB_CDEF) begin
            errors++;
            $display("FAIL full_write: got %h want %h", rdata, 64'h0123_4567_89AB_CDEF);
        end
        for (int a = 4; a <= 6; a += 2) begin
            set_addr(29'(a));
            checks++;
            if (rdata !== 64'h0) begin
                errors++;
                $display("FAIL full_write_neighbor%0d: got %h want %h", a, rdata, 64'h0);
            end
        end
    endtask

    task automatic test_byte_mask();
        do_write(29'd5, 64'hFFFF_FFFF_FFFF_FFFF, 8'h81, 1'b1);
        checks++;
        if (rdata !== 64'hFF23_4567_89AB_CDFF) begin
            errors++;
            $display("FAIL byte_mask_81: got %h want %h", rdata, 64'hFF23_4567_89AB_CDFF);
        end
        do_write(29'd5, 64'h0, 8'h00, 1'b1);
        checks++;
        if (rdata !== 64'hFF23_4567_89AB_CDFF) begin
            errors++;
            $display("FAIL byte_mask_00: got %h want %h", rdata, 64'hFF23_4567_89AB_CDFF);
        end
    endtask

    task automatic test_word_half();
        do_write(29'd7, 64'hAAAA_BBBB_0000_0000, 8'hF0, 1'b1);
        checks++;
        if (rdata !== 64'hAAAA_BBBB_0000_0000) begin
            errors++;
            $display("FAIL sw_upper: got %h want %h", rdata, 64'hAAAA_BBBB_0000_0000);
        end
        do_write(29'd7, 64'h0000_0000_0000_1234, 8'h03, 1'b1);
        checks++;
        if (rdata !== 64'hAAAA_BBBB_0000_1234) begin
            errors++;
            $display("FAIL sh_low: got %h want %h", rdata, 64'hAAAA_BBBB_0000_1234);
        end
    endtask

    task automatic test_wren_oor();
        do_write(29'd9, 64'h1, 8'hFF, 1'b0);
        checks++;
        if (rdata !== 64'h0) begin
            errors++;
            $display("FAIL wren_low: got %h want %h", rdata, 64'h0);
        end
        do_write(29'd0, 64'hA5A5_5A5A_0F0F_F0F0, 8'hFF, 1'b1);
        do_write(29'd512, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b1);
        checks++;
        if (rdata !== 64'h0) begin
            errors++;
            $display("FAIL oor_read: got %h want %h", rdata, 64'h0);
        end
        set_addr(29'd0);
        checks++;
        if (rdata !== 64'hA5A5_5A5A_0F0F_F0F0) begin
            errors++;
            $display("FAIL oor_no_wrap: got %h want %h", rdata, 64'hA5A5_5A5A_0F0F_F0F0);
        end
        set_addr(29'h1FFF_FE05);
        checks++;
        if (rdata !== 64'h0) begin
            errors++;
            $display("FAIL oor_high_addr: got %h want %h", rdata, 64'h0);
        end
    endtask

    task automatic test_rdw();
        @(negedge clk);
        addr = 29'd2; wdata = 64'h55; wmask = 8'hFF; wr_en = 1'b1;
        #1;
        checks++;
        if (rdata !== 64'h0) begin
            errors++;
            $display("FAIL rdw_before: got %h want %h", rdata, 64'h0);
        end
        @(posedge clk);
        #1;
        checks++;
        if (rdata !== 64'h55) begin
            errors++;
            $display("FAIL rdw_after: got %h want %h", rdata, 64'h55);
        end
        wr_en = 1'b0;
        wdata = 64'h99;
        @(posedge clk);
        #1;
        checks++;
        if (rdata !== 64'h55) begin
            errors++;
            $display("FAIL rdw_hold: got %h want %h", rdata, 64'h55);
        end
    endtask

    initial begin
        rst   = 1'b1;
        addr  = '0;
        wr_en = 1'b0;
        wdata = '0;
        wmask = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_full_write();
        test_byte_mask();
        test_word_half();
        test_wren_oor();
        test_rdw();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/data_mem_model.md
Name: data_mem_model

Overview:
- Behavioural data memory serving the pipelined RV64 processor's load/store port.
- Word-addressed array of 64-bit doublewords with per-byte write mask.
- Synchronous masked writes and combinational reads.
- Sits beside the processor in the top-level/simulation harness. The processor drives `addr[31:3]` as the doubleword index.

Parameters:
- DEPTH, 512, number of 64-bit words stored.
- ADDR_WIDE, 29, width of the word-address input (byte address bits [31:3]).

Ports:
- clk  input  1  single system clock; all writes on rising edge.
- rst  input  1  asynchronous, active-high reset; clears every word to 0.
- addr  input  ADDR_WIDE  doubleword index (byte address >> 3).
- rdata  output  64  combinational read data for word at addr.
- wr_en  input  1  write enable, sampled on rising clk.
- wdata  input  64  write data, byte lane i = bits [8i+7:8i].
- wmask  input  8  byte-lane write enables; bit i enables lane i.

Behaviour:
- Storage: DEPTH words × 64 bits, little-endian lanes; lane 0 = lowest byte address.
- Reset:
  - rst=1 asynchronously forces all words to 64'h0, immediately, independent of clk.
  - While rst=1, rdata=0 and writes are ignored.
  - Deassertion takes effect at the next rising edge; the first write can occur on that edge.
- Write:
  - On rising clk with rst=0, wr_en=1, and addr<DEPTH, each lane i with wmask[i]=1 takes wdata lane i.
  - Lanes with wmask[i]=0 keep their value.
  - wr_en=1 with wmask=0 leaves memory unchanged.
  - wr_en=0: no change regardless of wmask.
- Read:
  - rdata = mem[addr] combinationally, zero-latency, whenever rst=0 and addr<DEPTH.
  - No read enable.
- Out-of-range (addr ≥ DEPTH): reads return 64'h0; writes are dropped silently. No wrap-around or aliasing.
- Read-during-write, same address: before the edge rdata shows old data; after the edge (same delta-settled cycle) rdata shows merged new data. No forwarding of wdata.
- Sub-word stores are expressed via wmask:
  - sb: one bit.
  - sh: two adjacent bits.
  - sw: 8'h0F or 8'hF0.
  - sd: 8'hFF.
  - The block does not check alignment; any mask pattern is legal.
- Unknown/X on wr_en during normal operation is undefined; the bench never drives it.
- No internal state beyond the array; no FSM.

Decomposition:
- Shared package mem_pkg:
  - DATA_W=64, BYTE_W=8, NUM_LANES=DATA_W/BYTE_W.
  - Default DEPTH/ADDR_WIDE constants for data memory (512/29) and instruction memory (512/30).
- One natural sub-module: byte_lane_merge, a combinational function/module producing `(old & ~expand(wmask)) | (wdata & expand(wmask))`. It is reused by any future masked RAM.
- Array and address-range check stay in data_mem_model.

Test Plan:
- Reset clear:
  - Preload via writes: addr 3 ← 64'hDEADBEEF_CAFEF00D, mask FF.
  - Pulse rst mid-cycle (async, between edges).
  - rdata at addr 3 reads 0 immediately; remains 0 after rst drops.
- Full doubleword write/read: addr 5, wdata 64'h0123_4567_89AB_CDEF, mask FF, wr_en=1 → after edge rdata(addr 5)=64'h0123456789ABCDEF; other addresses still 0.
- Byte-lane masking:
  - From the state above, write wdata 64'hFFFF_FFFF_FFFF_FFFF, mask 8'h81 → rdata=64'hFF23_4567_89AB_CDFF.
  - Then mask 8'h00 with wr_en=1 → unchanged.
- Word/half stores:
  - addr 7 cleared; sw upper with wdata 64'hAAAA_BBBB_0000_0000, mask F0 → 64'hAAAABBBB00000000.
  - Then sh lane 0–1 with wdata 16'h1234, mask 03 → 64'hAAAABBBB00001234.
- wr_en low / out-of-range:
  - wr_en=0, mask FF, addr 9, wdata 1 → addr 9 stays 0.
  - addr=512 (DEPTH), wr_en=1, mask FF → no write; rdata=0; addr 0 unaffected (no wrap).
- Read-during-write timing: drive addr 2, wr_en=1, wdata 64'h55, mask FF. rdata=0 before the edge and 64'h55 after the edge. Next cycle with wr_en=0, rdata holds 64'h55.
